lut_coarse_loader: RTL
======================

# lut_coarse_loader

Sequential loader that builds the 64-entry coarse lookup table consumed by the quadratic-interpolation function stage. It accepts the full 256-entry sample table as a byte stream over a valid/ready handshake, keeps every fourth sample (index 4k → coarse entry k), and exposes three independent combinational read ports. The interpolator reads neighbouring entries x−1, x, x+1 through these ports every cycle.

## Interface
- `FULL_DEPTH`, default 256: number of input samples per load.
- `DECIM`, default 4: decimation factor (power of two); coarse depth = FULL_DEPTH/DECIM = 64.
- `DATA_W`, default 8: sample width.
- `clk`  input  1: single clock, all state updates on rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: begin a new load; honoured only in IDLE.
- `in_valid`  input  1: `in_data` holds a sample.
- `in_ready`  output  1: block accepts a sample this cycle.
- `in_data`  input  DATA_W: sample byte, samples sent in index order 0..FULL_DEPTH−1.
- `busy`  output  1: load in progress.
- `done`  output  1: one-cycle pulse, load finished.
- `table_valid`  output  1: table contents complete and consistent.
- `err`  output  1: sticky checksum error, only driven with the macro; otherwise 0.
- `rd_addr0/1/2`  input  6: coarse read addresses.
- `rd_data0/1/2`  output  DATA_W: coarse entries, combinational from the addresses.

## Operation
- States: IDLE, LOAD, CHECK (CHECK exists only with the macro).
- IDLE: `in_ready`=0, `busy`=0. When `start`=1, go to LOAD. Clear the 8-bit sample index, clear `table_valid` and clear `err`.
- LOAD: `in_ready`=1 and `busy`=1. A transfer occurs when `in_valid && in_ready`. Each transfer increments the index.
  - If index[1:0]==0 on a transfer, write `in_data` to coarse[index>>2]. Other samples are discarded.
- Last transfer (index==FULL_DEPTH−1):
  - Without the macro: go to IDLE, set `table_valid`, and pulse `done`.
  - With the macro: go to CHECK.
- `start` is ignored while in LOAD or CHECK. `in_valid` is ignored in IDLE.
- Read ports: `rd_dataN` = coarse[`rd_addrN`] at all times, including mid-load. Consumers gate their use on `table_valid`.
- Addresses are 6-bit and wrap naturally: the interpolator's x−1 at 0 reads entry 63, and x+1 at 63 reads entry 0.
- Reset: the table is cleared to all zeros, the state goes to IDLE, and all outputs are 0.

## Timing
- All outputs are registered, except `rd_dataN` (combinational) and `in_ready` (decoded from state).
- A coarse entry written on edge t is visible on `rd_dataN` immediately after edge t.
- `start` sampled high at edge t: `busy`=1 and `in_ready`=1 from t onward; `table_valid`=0 from t.
- Final data transfer at edge t (no macro): `done`=1 and `table_valid`=1 in the cycle after t; `done` drops after one cycle. `busy`=0 after t.
- Minimum load time is FULL_DEPTH cycles. Stalls (`in_valid`=0) add cycles with no state change.
- A new `start` is accepted in the same cycle that `done` is high, since the state is IDLE by then.
- Reset asserted mid-load aborts the load immediately. After reset there is no `done`, `table_valid` is 0, and the table is zero.

## Configuration
- `LUT_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) of all FULL_DEPTH accepted bytes is kept.
  - In CHECK, `in_ready`=1 and one extra byte is accepted.
  - If that byte equals the sum: `table_valid`=1 and `done` pulses.
  - On mismatch: `err`=1 (sticky until next `start` or reset), `table_valid` stays 0, and `done` still pulses.
  - The next state is IDLE in both cases.
- Not defined: no CHECK state, no sum register, and `err` is tied to 0.

## Test plan
- Ramp load: bytes 0..255 with `in_valid` always high. Required: `done` 1 cycle after the 256th transfer, `table_valid`=1, rd_addr0=5 → 20, rd_addr1=63 → 252, rd_addr2=0 → 0.
- Backpressure: the same ramp with `in_valid` low every other cycle. Required: identical table, `done` after 511 cycles.
- Wrap reads: load bytes 255−i, then set rd_addr0=63, rd_addr1=0, rd_addr2=1. Required: 3, 255, 251.
- Start during LOAD at sample 100 is ignored: the index continues and the load completes normally. A reload with all 0xAA clears `table_valid` at start and ends with every entry 0xAA.
- Reset asserted at sample 130: all entries 0, `busy`=0, `table_valid`=0, no `done` pulse.
- With `LUT_LOADER_CHECKSUM_EN`: ramp load followed by 0x80 (sum of 0..255 mod 256) gives `table_valid`=1 and `err`=0. Following with 0x81 instead gives `err`=1, `table_valid`=0, and `done` pulsed.

Source files
------------

// File: rtl/lut_coarse_loader.sv
// lut_coarse_loader: streams a FULL_DEPTH-sample table in over a valid/ready
// handshake and keeps every DECIM-th sample as a coarse lookup table. Three
// independent combinational read ports serve the x-1 / x / x+1 neighbours.
//
// Optional feature macro: LUT_LOADER_CHECKSUM_EN
//   When defined, an extra CHECK state accepts one trailing byte. The table
//   is declared valid only if that byte equals the 8-bit running sum of all
//   loaded samples; otherwise the sticky err flag is raised.
//
// Handshake: a sample moves on a rising edge where in_valid && in_ready.
// in_ready is decoded from state (LOAD, and CHECK when enabled), so it never
// depends on in_valid; the sender may hold in_valid high across cycles.
module lut_coarse_loader #(
  parameter int FULL_DEPTH = 256,
  parameter int DECIM      = 4,
  parameter int DATA_W     = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_W-1:0]                          in_data,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       table_valid,
  output logic                                       err,
  input  logic [$clog2(FULL_DEPTH/DECIM)-1:0]        rd_addr0,
  input  logic [$clog2(FULL_DEPTH/DECIM)-1:0]        rd_addr1,
  input  logic [$clog2(FULL_DEPTH/DECIM)-1:0]        rd_addr2,
  output logic [DATA_W-1:0]                          rd_data0,
  output logic [DATA_W-1:0]                          rd_data1,
  output logic [DATA_W-1:0]                          rd_data2
);

  localparam int COARSE_DEPTH = FULL_DEPTH / DECIM;
  localparam int IDX_W        = $clog2(FULL_DEPTH);
  localparam int CA_W         = $clog2(COARSE_DEPTH);
  localparam int SH           = $clog2(DECIM);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FULL_DEPTH - 1);
  localparam logic [IDX_W-1:0] DEC_MASK  = IDX_W'(DECIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1
`ifdef LUT_LOADER_CHECKSUM_EN
    ,
    S_CHECK = 2'd2
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tv_q, tv_d;
  logic                wr_en;
  logic [CA_W-1:0]     wr_addr;
  logic                xfer;
  logic [DATA_W-1:0]   coarse_q [COARSE_DEPTH];
`ifdef LUT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                err_q, err_d;
`endif

`ifdef LUT_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign err      = err_q;
`else
  assign in_ready = (state_q == S_LOAD);
  assign err      = 1'b0;
`endif

  assign xfer        = in_valid && in_ready;
  assign busy        = busy_q;
  assign done        = done_q;
  assign table_valid = tv_q;

  // Reads bypass all state: consumers gate on table_valid themselves.
  assign rd_data0 = coarse_q[rd_addr0];
  assign rd_data1 = coarse_q[rd_addr1];
  assign rd_data2 = coarse_q[rd_addr2];

  // Next-state, index, status flags and table write decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tv_d    = tv_q;
    wr_en   = 1'b0;
    wr_addr = CA_W'(idx_q >> SH);
`ifdef LUT_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
          tv_d    = 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          // Only samples on a decimation boundary land in the coarse table.
          if ((idx_q & DEC_MASK) == '0) wr_en = 1'b1;
`ifdef LUT_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef LUT_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tv_d    = 1'b1;
`endif
          end
        end
      end
`ifdef LUT_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tv_d    = (in_data == sum_q);
          err_d   = (in_data != sum_q);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and status registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tv_q    <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tv_q    <= tv_d;
`ifdef LUT_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Coarse table storage, cleared to zero by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < COARSE_DEPTH; k++) coarse_q[k] <= '0;
    end else if (wr_en) begin
      coarse_q[wr_addr] <= in_data;
    end
  end

endmodule
